ts_packet_aligner: RTL and testbench

//  Downstream stage of the CAM interface: consumes its byte stream (CAM-processed or bypass)
//  and recovers 188-byte MPEG-TS packet framing from the 0x47 sync byte.

---
 rtl/t2mi_ts_pkg.sv | 15 +
 rtl/ts_packet_aligner.sv | 142 ++++++++++++++
 tb/tb_ts_packet_aligner.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t2mi_ts_pkg.sv
// Shared MPEG-TS framing constants and aligner state encoding.
package t2mi_ts_pkg;

  localparam int         TS_PKT_LEN       = 188;
  localparam logic [7:0] TS_SYNC_BYTE     = 8'h47;
  localparam int         TS_LOCK_THRESH   = 3;
  localparam int         TS_UNLOCK_THRESH = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_packet_aligner.sv
// Recovers 188-byte TS packet framing from the sync byte and forwards only
// aligned packets with sop/eop markers, tracking lock and sync loss.
module ts_packet_aligner
  import t2mi_ts_pkg::*;
#(
  parameter int         PKT_LEN       = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE     = TS_SYNC_BYTE,
  parameter int         LOCK_THRESH   = TS_LOCK_THRESH,
  parameter int         UNLOCK_THRESH = TS_UNLOCK_THRESH
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        resync,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        out_abort,
  output logic        locked,
  output logic [15:0] sync_loss_cnt,
  output logic [15:0] pkt_cnt
);

  localparam int                 POS_W       = $clog2(PKT_LEN);
  localparam int                 CNT_W       = 8;
  localparam logic [POS_W-1:0]   POS_LAST    = POS_W'(PKT_LEN - 1);
  // Thresholds pre-decremented so "count + 1 == THRESH" becomes a plain compare.
  localparam logic [CNT_W-1:0]   LOCK_GOAL   = CNT_W'(LOCK_THRESH - 1);
  localparam logic [CNT_W-1:0]   UNLOCK_GOAL = CNT_W'(UNLOCK_THRESH - 1);

  ts_state_e         state;
  logic [POS_W-1:0]  pos;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  bad_cnt;

  logic              is_sync;
  logic              at_slot;
  logic [POS_W-1:0]  pos_next;

  assign is_sync  = (in_data == SYNC_BYTE);
  assign at_slot  = (pos == '0);
  assign pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);

  // pos always names the position of the byte about to arrive, so a resync
  // with pos != 0 means a forwarded packet is only partly out.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      pos           <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_err       <= 1'b0;
      out_abort     <= 1'b0;
      locked        <= 1'b0;
      sync_loss_cnt <= '0;
      pkt_cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      out_abort <= 1'b0;

      if (resync) begin
        out_abort <= (state == LOCK) && !at_slot;
        state     <= HUNT;
        locked    <= 1'b0;
        pos       <= '0;
        good_cnt  <= '0;
        bad_cnt   <= '0;
      end else if (in_valid) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              state    <= VERIFY;
              pos      <= POS_W'(1);
              good_cnt <= CNT_W'(1);
            end
          end

          VERIFY: begin
            if (!at_slot) begin
              pos <= pos_next;
            end else if (is_sync && good_cnt == LOCK_GOAL) begin
              state     <= LOCK;
              locked    <= 1'b1;
              bad_cnt   <= '0;
              pos       <= pos_next;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_sop   <= 1'b1;
            end else if (is_sync) begin
              good_cnt <= good_cnt + CNT_W'(1);
              pos      <= pos_next;
            end else begin
              state    <= HUNT;
              good_cnt <= '0;
              pos      <= '0;
            end
          end

          LOCK: begin
            if (at_slot && !is_sync && bad_cnt == UNLOCK_GOAL) begin
              state    <= HUNT;
              locked   <= 1'b0;
              pos      <= '0;
              good_cnt <= '0;
              bad_cnt  <= '0;
              if (sync_loss_cnt != 16'hFFFF)
                sync_loss_cnt <= sync_loss_cnt + 16'd1;
            end else begin
              pos       <= pos_next;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_sop   <= at_slot;
              out_err   <= at_slot && !is_sync;
              out_eop   <= (pos == POS_LAST);
              if (pos == POS_LAST)
                pkt_cnt <= pkt_cnt + 16'd1;
              if (at_slot)
                bad_cnt <= is_sync ? '0 : bad_cnt + CNT_W'(1);
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            pos    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Self-checking bench for ts_packet_aligner: directed tables, hand sequences
// and a randomized stream compared cycle by cycle against a stream-index model.
module tb_ts_packet_aligner;

  localparam int         PKT_LEN       = 188;
  localparam logic [7:0] SYNC          = 8'h47;
  localparam int         LOCK_THRESH   = 3;
  localparam int         UNLOCK_THRESH = 3;

  logic        clk_100mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        in_valid   = 1'b0;
  logic [7:0]  in_data    = '0;
  logic        resync     = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic        out_abort;
  logic        locked;
  logic [15:0] sync_loss_cnt;
  logic [15:0] pkt_cnt;

  ts_packet_aligner dut (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .resync        (resync),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_err       (out_err),
    .out_abort     (out_abort),
    .locked        (locked),
    .sync_loss_cnt (sync_loss_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int errors = 0;
  int checks = 0;

  // Reference model: framing is judged from absolute stream indices, with the
  // expected sync slots being anchorIdx + k*PKT_LEN.
  int          byteIdx;
  int          anchorIdx;
  int          goodSyncs;
  int          badSyncs;
  bit          mLocked;
  logic        expV, expSop, expEop, expErr, expAbort, expLocked;
  logic [7:0]  expData;
  logic [15:0] expSyncLoss;
  logic [15:0] expPkt;

  int          fwdCnt, sopCnt, eopCnt;
  logic [7:0]  fwdQ[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rs;
    logic       eValid;
    logic       eLocked;
    logic       eAbort;
  } vec_t;
  vec_t tbl[$];

  task automatic modelReset();
    byteIdx = 0; anchorIdx = -1; goodSyncs = 0; badSyncs = 0; mLocked = 0;
    expV = 0; expSop = 0; expEop = 0; expErr = 0; expAbort = 0; expLocked = 0;
    expData = '0; expSyncLoss = '0; expPkt = '0;
  endtask

  task automatic clearMon();
    fwdCnt = 0; sopCnt = 0; eopCnt = 0;
    fwdQ.delete();
  endtask

  task automatic modelEmit(input logic [7:0] d, input int rel, input bit sync);
    expV    = 1;
    expData = d;
    expSop  = (rel == 0);
    expEop  = (rel == PKT_LEN - 1);
    expErr  = (rel == 0) && !sync;
    if (expEop) expPkt = expPkt + 16'd1;
  endtask

  task automatic modelStep(input logic v, input logic [7:0] d, input logic rs);
    bit sync;
    int rel;
    expV = 0; expSop = 0; expEop = 0; expErr = 0; expAbort = 0;
    sync = (d == SYNC);
    if (rs) begin
      expAbort  = mLocked && (((byteIdx - anchorIdx) % PKT_LEN) != 0);
      anchorIdx = -1; mLocked = 0; goodSyncs = 0; badSyncs = 0;
    end else if (v) begin
      if (anchorIdx < 0) begin
        if (sync) begin
          anchorIdx = byteIdx;
          goodSyncs = 1;
        end
      end else begin
        rel = (byteIdx - anchorIdx) % PKT_LEN;
        if (!mLocked) begin
          if (rel == 0 && !sync) begin
            anchorIdx = -1; goodSyncs = 0;
          end else if (rel == 0) begin
            goodSyncs++;
            if (goodSyncs >= LOCK_THRESH) begin
              mLocked  = 1;
              badSyncs = 0;
              modelEmit(d, rel, sync);
            end
          end
        end else if (rel == 0 && !sync && badSyncs + 1 >= UNLOCK_THRESH) begin
          anchorIdx = -1; mLocked = 0; badSyncs = 0; goodSyncs = 0;
          if (expSyncLoss != 16'hFFFF) expSyncLoss = expSyncLoss + 16'd1;
        end else begin
          if (rel == 0) badSyncs = sync ? 0 : badSyncs + 1;
          modelEmit(d, rel, sync);
        end
      end
      byteIdx++;
    end
    expLocked = mLocked;
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [45:0] act, exp;
    act = {out_valid, out_data, out_sop, out_eop, out_err, out_abort, locked, sync_loss_cnt, pkt_cnt};
    exp = {expV, expData, expSop, expEop, expErr, expAbort, expLocked, expSyncLoss, expPkt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL cycle_compare: got v=%0b d=%0h sop=%0b eop=%0b err=%0b abort=%0b lock=%0b loss=%0d pkts=%0d expected v=%0b d=%0h sop=%0b eop=%0b err=%0b abort=%0b lock=%0b loss=%0d pkts=%0d at %0t",
               out_valid, out_data, out_sop, out_eop, out_err, out_abort, locked, sync_loss_cnt, pkt_cnt,
               expV, expData, expSop, expEop, expErr, expAbort, expLocked, expSyncLoss, expPkt, $time);
    end
    if (out_valid) begin
      fwdCnt++;
      if (out_sop) sopCnt++;
      if (out_eop) eopCnt++;
      fwdQ.push_back(out_data);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rs);
    in_valid = v;
    in_data  = d;
    resync   = rs;
    modelStep(v, d, rs);
    @(posedge clk_100mhz);
    #1;
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] d, input int gapPct);
    int n = 0;
    while (n < 8 && $urandom_range(0, 99) < gapPct) begin
      applyStimulus(1'b0, 8'($urandom), 1'b0);
      n++;
    end
    applyStimulus(1'b1, d, 1'b0);
  endtask

  task automatic sendBody(input int gapPct);
    for (int i = 1; i < PKT_LEN; i++) sendByte(8'(i), gapPct);
  endtask

  task automatic sendPacket(input logic [7:0] s, input int gapPct);
    sendByte(s, gapPct);
    sendBody(gapPct);
  endtask

  task automatic doReset();
    rst_n = 1'b0; in_valid = 1'b0; resync = 1'b0;
    modelReset();
    clearMon();
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] g;
    int         mism;

    modelReset();
    clearMon();

    // Reset held with random input: every output must stay zero.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      resync   = 1'($urandom);
      @(posedge clk_100mhz);
      #1;
      checkValue("reset_outs", {out_valid, out_data, out_sop, out_eop, out_err, out_abort,
                                locked, sync_loss_cnt, pkt_cnt}, 64'd0);
    end
    in_valid = 1'b0; resync = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkValue("release_locked", locked, 0);
    checkValue("release_loss", sync_loss_cnt, 0);
    checkValue("release_pkts", pkt_cnt, 0);

    // Short HUNT/VERIFY vectors: nothing is forwarded before lock.
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h47, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].rs);
      checkValue("tbl_valid", out_valid, tbl[i].eValid);
      checkValue("tbl_locked", locked, tbl[i].eLocked);
      checkValue("tbl_abort", out_abort, tbl[i].eAbort);
    end

    $display("[TB] three back-to-back packets");
    doReset();
    sendPacket(SYNC, 0);
    sendPacket(SYNC, 0);
    sendByte(SYNC, 0);
    checkValue("lock_on_third", locked, 1);
    checkValue("third_sop", {out_valid, out_sop, out_data}, {1'b1, 1'b1, SYNC});
    sendBody(0);
    checkValue("third_eop", {out_eop, out_data}, {1'b1, 8'hBB});
    checkValue("pkts_after_3", pkt_cnt, 1);
    checkValue("fwd_bytes_3", fwdCnt, PKT_LEN);
    checkValue("sop_count_3", sopCnt, 1);

    $display("[TB] garbage then five packets");
    doReset();
    for (int i = 0; i < 50; i++) begin
      g = 8'($urandom);
      if (g == SYNC) g = 8'h00;
      sendByte(g, 0);
    end
    repeat (5) sendPacket(SYNC, 0);
    checkValue("pkts_after_5", pkt_cnt, 3);
    checkValue("fwd_bytes_5", fwdCnt, 3 * PKT_LEN);

    $display("[TB] corrupted syncs while locked");
    sendByte(8'h00, 0);
    checkValue("corrupt_sop_err", {out_valid, out_sop, out_err}, 3'b111);
    checkValue("corrupt_still_locked", locked, 1);
    sendBody(0);
    sendPacket(SYNC, 0);
    sendPacket(8'h00, 0);
    sendPacket(8'h00, 0);
    sendByte(8'h00, 0);
    checkValue("unlock_no_fwd", out_valid, 0);
    checkValue("unlock_locked", locked, 0);
    checkValue("unlock_loss", sync_loss_cnt, 1);
    sendBody(0);

    $display("[TB] three packets with input gaps");
    doReset();
    repeat (3) sendPacket(SYNC, 50);
    checkValue("gap_fwd_bytes", fwdCnt, PKT_LEN);
    checkValue("gap_sop_eop", {sopCnt[7:0], eopCnt[7:0]}, 16'h0101);
    checkValue("gap_pkts", pkt_cnt, 1);
    mism = 0;
    for (int i = 0; i < PKT_LEN; i++) begin
      g = (i == 0) ? SYNC : 8'(i);
      if (i >= fwdQ.size() || fwdQ[i] !== g) mism++;
    end
    checkValue("gap_sequence", mism, 0);

    $display("[TB] resync mid-packet");
    sendByte(SYNC, 0);
    for (int i = 1; i < 100; i++) sendByte(8'(i), 0);
    applyStimulus(1'b1, 8'd100, 1'b1);
    checkValue("abort_pulse", {out_abort, out_valid}, 2'b10);
    checkValue("abort_unlocked", locked, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkValue("abort_one_cycle", out_abort, 0);
    checkValue("abort_no_loss", sync_loss_cnt, 0);
    sendPacket(SYNC, 0);
    sendPacket(SYNC, 0);
    sendByte(SYNC, 0);
    checkValue("relock", locked, 1);
    sendBody(0);

    $display("[TB] randomized stream");
    doReset();
    for (int seg = 0; seg < 45; seg++) begin
      int kind = $urandom_range(0, 9);
      if (kind == 0) begin
        applyStimulus(1'($urandom), 8'($urandom), 1'b1);
      end else if (kind == 1) begin
        for (int i = 0; i < $urandom_range(1, 30); i++) sendByte(8'($urandom), 30);
      end else begin
        g = ($urandom_range(0, 5) == 0) ? 8'($urandom) : SYNC;
        sendByte(g, 30);
        for (int i = 1; i < PKT_LEN; i++) begin
          if ($urandom_range(0, 399) == 0)
            applyStimulus(1'($urandom), 8'($urandom), 1'b1);
          else
            sendByte(8'($urandom), 30);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
